// File: rtl/pwm_pkg.sv
// pwm_pkg: shared channel count, channel indices and pin-level helper for the RGB PWM driver
package pwm_pkg;
  localparam int NUM_CH = 3;
  typedef enum logic [1:0] {CH_R = 2'd0, CH_G = 2'd1, CH_B = 2'd2} ch_e;
  function automatic logic led_level(input logic on, input logic active_low);
    return on ^ active_low;
  endfunction
endpackage

// File: rtl/pwm_rgb_driver_channel.sv
// pwm_rgb_driver_channel: double-buffered duty (shadow/active) and counter compare for one colour
module pwm_rgb_driver_channel #(
  parameter int DW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] cnt,
  input  logic          swap,
  input  logic          en,
  input  logic          duty_valid,
  input  logic [DW-1:0] duty_in,
  output logic          on
);
  logic [DW-1:0] shadow_q, shadow_d, active_q, active_d;
  // shadow_d already carries a same-cycle duty_in, which gives the swap bypass for free
  always_comb begin
    shadow_d = duty_valid ? duty_in : shadow_q;
    active_d = (swap || !en) ? shadow_d : active_q;
    on = en && (cnt < active_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end
endmodule

// File: rtl/pwm_rgb_driver.sv
// pwm_rgb_driver: three-channel PWM stage with period-aligned duty updates and registered pins
module pwm_rgb_driver
  import pwm_pkg::*;
#(
  parameter int PWM_INTERVAL = 1200,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int DW           = $clog2(PWM_INTERVAL)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 duty_valid,
  input  logic [2:0][DW-1:0]   duty_in,
  output logic [NUM_CH-1:0]    led,
  output logic                 period_start
);
  localparam logic [DW-1:0] LAST = DW'(PWM_INTERVAL - 1);
  logic [DW-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0] on, led_d, led_q;
  logic ps_d, ps_q, swap;
  always_comb begin
    swap = en && (cnt_q == LAST);
    cnt_d = (!en || swap) ? '0 : cnt_q + 1'b1;
    ps_d = en && (cnt_q == '0);
    for (int i = 0; i < NUM_CH; i++) led_d[i] = led_level(on[i], ACTIVE_LOW);
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pwm_rgb_driver_channel #(.DW(DW)) u_ch (
      .clk(clk),
      .rst(rst),
      .cnt(cnt_q),
      .swap(swap),
      .en(en),
      .duty_valid(duty_valid),
      .duty_in(duty_in[c]),
      .on(on[c])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      led_q <= {NUM_CH{ACTIVE_LOW}};
      ps_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      led_q <= led_d;
      ps_q <= ps_d;
    end
  end
  assign led = led_q;
  assign period_start = ps_q;
endmodule

// File: tb/tb_pwm_rgb_driver.sv
// tb_pwm_rgb_driver: directed checks of PWM timing, double buffering, reset and enable on both pin polarities
module tb_pwm_rgb_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic dv = 1'b0;
  logic [2:0][3:0] duty = '0;
  logic [2:0] led_al, led_ah;
  logic ps_al, ps_ah;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  pwm_rgb_driver #(.PWM_INTERVAL(10), .ACTIVE_LOW(1'b1), .DW(4)) u_al (
    .clk(clk), .rst(rst), .en(en), .duty_valid(dv), .duty_in(duty),
    .led(led_al), .period_start(ps_al)
  );
  pwm_rgb_driver #(.PWM_INTERVAL(10), .ACTIVE_LOW(1'b0), .DW(4)) u_ah (
    .clk(clk), .rst(rst), .en(en), .duty_valid(dv), .duty_in(duty),
    .led(led_ah), .period_start(ps_ah)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [9:0] pat(input int d);
    logic [10:0] m;
    m = (11'd1 << d) - 11'd1;
    return d >= 10 ? 10'h3ff : m[9:0];
  endfunction
  task automatic wait_ps(input string tag);
    for (int i = 0; i < 40 && !ps_al; i++) @(negedge clk);
    chk({tag, "_ps_wait"}, 32'(ps_al), 32'd1);
  endtask
  // Starts at a negedge where period_start is high; optional R duty pulse at sample dj (lands at cnt=dj+1)
  task automatic cap(input string tag, input int r, input int g, input int b, input int dj, input logic [3:0] dr);
    logic [2:0][9:0] o_al, o_ah;
    logic [9:0] p_al, p_ah;
    int d[3];
    d[0] = r; d[1] = g; d[2] = b;
    for (int j = 0; j < 10; j++) begin
      p_al[j] = ps_al;
      p_ah[j] = ps_ah;
      for (int c = 0; c < 3; c++) begin
        o_al[c][j] = ~led_al[c];
        o_ah[c][j] = led_ah[c];
      end
      dv = (j == dj);
      if (j == dj) duty[0] = dr;
      @(negedge clk);
    end
    dv = 1'b0;
    chk({tag, "_ps_al"}, 32'(p_al), 32'h1);
    chk({tag, "_ps_ah"}, 32'(p_ah), 32'h1);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("%s_al_ch%0d", tag, c), 32'(o_al[c]), 32'(pat(d[c])));
      chk($sformatf("%s_ah_ch%0d", tag, c), 32'(o_ah[c]), 32'(pat(d[c])));
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_led_al"}, 32'(led_al), 32'h7);
    chk({tag, "_led_ah"}, 32'(led_ah), 32'h0);
    chk({tag, "_ps"}, 32'(ps_al | ps_ah), 32'h0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    en = 1'b1;
    duty[0] = 4'd3; duty[1] = 4'd0; duty[2] = 4'd10;
    dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    wait_ps("s1");
    cap("s1_p0", 0, 0, 0, -1, 4'd0);
    cap("s1_p1", 3, 0, 10, -1, 4'd0);
    cap("s1_p2", 3, 0, 10, -1, 4'd0);
    cap("s2_p0", 3, 0, 10, 1, 4'd7);
    cap("s2_p1", 7, 0, 10, -1, 4'd0);
    cap("s3_p0", 7, 0, 10, 8, 4'd5);
    cap("s3_p1", 5, 0, 10, 3, 4'd15);
    cap("s3_p2", 15, 0, 10, -1, 4'd0);
    repeat (3) @(negedge clk);
    chk("s4_r_on", 32'(led_al[0]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("s4_rst");
    rst = 1'b0;
    duty = '0;
    wait_ps("s4");
    cap("s4_p0", 0, 0, 0, 2, 4'd8);
    cap("s5_p0", 8, 0, 0, -1, 4'd0);
    en = 1'b0;
    @(negedge clk);
    chk_idle("s5_dis");
    duty[0] = 4'd2;
    dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("s5_hold");
    en = 1'b1;
    @(negedge clk);
    chk("s5_first_ps", 32'(ps_al), 32'd1);
    wait_ps("s5");
    cap("s5_p1", 2, 0, 0, -1, 4'd0);
    cap("s5_p2", 2, 0, 0, -1, 4'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
